// File: rtl/obuf_a_data_pkg.sv
// Shared definitions for the router output-buffer data path: port count,
// port index names and the one-hot grant check.
package obuf_a_data_pkg;

  localparam int NUM_PORTS = 5;

  // Input buffer index for each direction; bit i of a grant selects port i.
  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_E = 3'd1,
    PORT_S = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } port_idx_e;

  // True when exactly one bit of the grant vector is set.
  function automatic logic is_onehot(input logic [NUM_PORTS-1:0] v);
    int ones;
    ones = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      ones += int'(v[i]);
    end
    return (ones == 1);
  endfunction

endpackage

// File: rtl/obuf_a_data_fifo.sv
// Generic DEPTH x W circular FIFO with occupancy count and a synchronous
// clear. The head entry is kept in its own register so the output is a
// clean flop with no combinational path from wr/rd/clr.
module obuf_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 23,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr,
  input  logic [W-1:0]     wr_data,
  input  logic             rd,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next,
  output logic [W-1:0]     head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg;
  logic [W-1:0]     head_reg, head_next;
  logic             wr_ok;
  logic             rd_ok;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Clear wins over both ports; guards keep a stray wr/rd from corrupting state.
  assign wr_ok = wr & ~clr & (count_reg < CNT_W'(DEPTH));
  assign rd_ok = rd & ~clr & (count_reg != '0);

  // Next pointers, count and head entry.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    head_next   = head_reg;
    if (clr) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (wr_ok) wr_ptr_next = ptr_inc(wr_ptr_reg);
      if (rd_ok) rd_ptr_next = ptr_inc(rd_ptr_reg);
      if (wr_ok && !rd_ok) count_next = count_reg + 1'b1;
      if (rd_ok && !wr_ok) count_next = count_reg - 1'b1;
      // Refresh head only when something will be stored; when empty it
      // keeps the last value read. Bypass when the new write lands at head.
      if (count_next != '0) begin
        if (wr_ok && (wr_ptr_reg == rd_ptr_next)) head_next = wr_data;
        else                                      head_next = mem[rd_ptr_next];
      end
    end
  end

  // Storage array: one write-enabled row per entry, not reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    always_ff @(posedge clk) begin
      if (wr_ok && (wr_ptr_reg == PTR_W'(gi))) mem[gi] <= wr_data;
    end
  end

  // Control and head registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
    end
  end

  assign count = count_reg;
  assign head  = head_reg;

endmodule

// File: rtl/obuf_a_data.sv
// A-channel output buffer of one router output port: muxes the granted
// input-buffer payload into a small FIFO and drives it to the neighbour
// over valid/ready.
module obuf_a_data
  import obuf_a_data_pkg::*;
#(
  parameter int PYLD_W = 23,
  parameter int DEPTH  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pg_en,
  input  logic [NUM_PORTS-1:0]        arb_gnt,
  input  logic [NUM_PORTS-1:0]        in_vld,
  input  logic [NUM_PORTS*PYLD_W-1:0] payload_i,
  output logic                        obuf_rdy,
  output logic                        obuf_vld,
  input  logic                        nbr_rdy,
  output logic [PYLD_W-1:0]           payload_o,
  output logic                        gnt_err
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PYLD_W-1:0] masked [NUM_PORTS];
  logic [PYLD_W-1:0] wr_data;
  logic              wr;
  logic              rd;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              obuf_rdy_reg, obuf_rdy_next;
  logic              gnt_err_reg, gnt_err_next;

  // Gate each input payload by its grant bit.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_mask
    assign masked[gi] = payload_i[gi*PYLD_W +: PYLD_W] & {PYLD_W{arb_gnt[gi]}};
  end

  // OR the gated payloads together; a bad multi-hot grant ORs them.
  always_comb begin
    wr_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      wr_data = wr_data | masked[i];
    end
  end

  assign wr = obuf_rdy_reg & (|(arb_gnt & in_vld));
  assign rd = obuf_vld & nbr_rdy;

  obuf_fifo #(
    .DEPTH (DEPTH),
    .W     (PYLD_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clr        (pg_en),
    .wr         (wr),
    .wr_data    (wr_data),
    .rd         (rd),
    .count      (count),
    .count_next (count_next),
    .head       (payload_o)
  );

  // Ready reflects occupancy after this edge; power gate forces it low.
  always_comb begin
    obuf_rdy_next = (count_next < CNT_W'(DEPTH)) & ~pg_en;
    gnt_err_next  = gnt_err_reg | (wr & ~is_onehot(arb_gnt));
  end

  // Ready and sticky grant-error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      obuf_rdy_reg <= 1'b0;
      gnt_err_reg  <= 1'b0;
    end else begin
      obuf_rdy_reg <= obuf_rdy_next;
      gnt_err_reg  <= gnt_err_next;
    end
  end

  assign obuf_rdy = obuf_rdy_reg;
  assign obuf_vld = (count != '0);
  assign gnt_err  = gnt_err_reg;

endmodule
